// File: rtl/jstk2_pkg.sv
// Shared types and constants for the Pmod JSTK2 SPI reader.
// Holds the packet framing constants, the FSM state type and the axis decode helper.
package jstk2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_GAP,
      ST_PGAP
   } state_t;

   localparam logic [7:0] JSTK2_CMD_LED   = 8'h84;
   localparam logic [7:0] JSTK2_CMD_NOP   = 8'h00;
   localparam int         JSTK2_PKT_BYTES = 5;
   localparam int         JSTK2_AXIS_W    = 10;

   // The JSTK2 sends each axis low byte first; only bits [1:0] of the high byte are meaningful.
   function automatic logic [JSTK2_AXIS_W-1:0] axis_decode(input logic [7:0] lo,
                                                           input logic [7:0] hi);
      return {hi[1:0], lo};
   endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// Mode-0 full-duplex 8-bit SPI shifter, MSB first, with its own SCLK half-period timer.
// A start pulse begins the low phase on the next edge; done is high in the byte's final cycle.
module spi_byte_shifter #(
   parameter int SCLK_HALF_CYC = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] tx_byte,
   output logic       done,
   output logic [7:0] rx_byte,
   input  logic       MISO,
   output logic       MOSI,
   output logic       SCLK
);

   localparam int HW = (SCLK_HALF_CYC > 1) ? $clog2(SCLK_HALF_CYC) : 1;

   logic          active;
   logic [HW-1:0] hcnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    tx_sh;
   logic [7:0]    rx_sh;
   logic          half_end;

   assign half_end = (hcnt == HW'(SCLK_HALF_CYC - 1));
   assign done     = active && SCLK && half_end && (bit_cnt == 3'd7);
   assign rx_byte  = rx_sh;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         active  <= 1'b0;
         hcnt    <= '0;
         bit_cnt <= '0;
         tx_sh   <= '0;
         rx_sh   <= '0;
         MOSI    <= 1'b0;
         SCLK    <= 1'b0;
      end else if (start) begin
         active  <= 1'b1;
         hcnt    <= '0;
         bit_cnt <= '0;
         SCLK    <= 1'b0;
         MOSI    <= tx_byte[7];
         tx_sh   <= {tx_byte[6:0], 1'b0};
      end else if (active) begin
         if (!half_end) begin
            hcnt <= hcnt + 1'b1;
         end else begin
            hcnt <= '0;
            if (!SCLK) begin
               SCLK  <= 1'b1;
               rx_sh <= {rx_sh[6:0], MISO};
            end else begin
               SCLK <= 1'b0;
               if (bit_cnt == 3'd7) begin
                  active <= 1'b0;
                  MOSI   <= 1'b0;
               end else begin
                  // Falling edge opens the next low phase: present the next MOSI bit now.
                  bit_cnt <= bit_cnt + 1'b1;
                  MOSI    <= tx_sh[7];
                  tx_sh   <= {tx_sh[6:0], 1'b0};
               end
            end
         end
      end
   end

endmodule

// File: rtl/jstk2_spi_reader.sv
// Continuous Pmod JSTK2 poller: frames 5-byte SPI packets, decodes both axes and buttons,
// and optionally carries a pending set-LED command in the next packet.
module jstk2_spi_reader
   import jstk2_pkg::*;
#(
   parameter int SCLK_HALF_CYC = 1000,
   parameter int SS_SETUP_CYC  = 1500,
   parameter int BYTE_GAP_CYC  = 1000,
   parameter int PKT_GAP_CYC   = 2500,
   parameter int SWAP_XY       = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [23:0]             led_rgb,
   input  logic                    led_wr,
   input  logic                    MISO,
   output logic                    MOSI,
   output logic                    SS,
   output logic                    SCLK,
   output logic [JSTK2_AXIS_W-1:0] x_val,
   output logic [JSTK2_AXIS_W-1:0] y_val,
   output logic                    btn_stick,
   output logic                    btn_trig,
   output logic                    data_valid,
   output logic                    busy
);

   localparam int MAX_SG  = (SS_SETUP_CYC > BYTE_GAP_CYC) ? SS_SETUP_CYC : BYTE_GAP_CYC;
   localparam int CNT_MAX = (MAX_SG > PKT_GAP_CYC) ? MAX_SG : PKT_GAP_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [2:0] LAST_BYTE = 3'(JSTK2_PKT_BYTES - 1);

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [2:0]      byte_idx;
   logic [7:0]      tx_buf [JSTK2_PKT_BYTES];
   logic [7:0]      rx_buf [JSTK2_PKT_BYTES-1];
   logic            led_pend;
   logic [23:0]     led_val;
   logic            start;
   logic            done;
   logic [7:0]      rx_byte;
   logic            pkt_start;
   logic            byte_done;
   logic [JSTK2_AXIS_W-1:0] x_dec, y_dec;

   spi_byte_shifter #(
      .SCLK_HALF_CYC(SCLK_HALF_CYC)
   ) u_shifter (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .tx_byte (tx_buf[byte_idx]),
      .done    (done),
      .rx_byte (rx_byte),
      .MISO    (MISO),
      .MOSI    (MOSI),
      .SCLK    (SCLK)
   );

   assign pkt_start = (state == ST_IDLE) && en;
   assign byte_done = (state == ST_SHIFT) && done;
   assign busy      = (state != ST_IDLE);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      case (state)
         ST_IDLE:  if (en) state_nxt = ST_SETUP;
         ST_SETUP: if (cnt == CW'(SS_SETUP_CYC - 1)) begin
            state_nxt = ST_SHIFT;
            start     = 1'b1;
         end
         ST_SHIFT: if (done) state_nxt = (byte_idx == LAST_BYTE) ? ST_PGAP : ST_GAP;
         ST_GAP:   if (cnt == CW'(BYTE_GAP_CYC - 1)) begin
            state_nxt = ST_SHIFT;
            start     = 1'b1;
         end
         ST_PGAP:  if (cnt == CW'(PKT_GAP_CYC - 1)) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // The fifth byte is still in the shifter on the PGAP entry edge, so buttons come from rx_byte.
   assign x_dec = axis_decode(rx_buf[0], rx_buf[1]);
   assign y_dec = axis_decode(rx_buf[2], rx_buf[3]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         byte_idx   <= '0;
         SS         <= 1'b1;
         x_val      <= '0;
         y_val      <= '0;
         btn_stick  <= 1'b0;
         btn_trig   <= 1'b0;
         data_valid <= 1'b0;
         led_pend   <= 1'b0;
         led_val    <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= (state_nxt != state) ? '0 : cnt + 1'b1;
         SS         <= !(state_nxt inside {ST_SETUP, ST_SHIFT, ST_GAP});
         data_valid <= 1'b0;

         if (pkt_start) byte_idx <= '0;
         else if (byte_done && byte_idx != LAST_BYTE) byte_idx <= byte_idx + 1'b1;

         // A write on the SS-fall edge must survive the clear, so it lands in the next packet.
         if (led_wr) begin
            led_pend <= 1'b1;
            led_val  <= led_rgb;
         end else if (pkt_start) begin
            led_pend <= 1'b0;
         end

         if (byte_done && byte_idx == LAST_BYTE) begin
            x_val      <= (SWAP_XY != 0) ? y_dec : x_dec;
            y_val      <= (SWAP_XY != 0) ? x_dec : y_dec;
            btn_stick  <= rx_byte[0];
            btn_trig   <= rx_byte[1];
            data_valid <= 1'b1;
         end
      end
   end

   // NOTE: byte buffers are not reset; each entry is always written before it is read.
   always_ff @(posedge clk) begin
      if (pkt_start) begin
         if (led_pend) begin
            tx_buf[0] <= JSTK2_CMD_LED;
            tx_buf[1] <= led_val[23:16];
            tx_buf[2] <= led_val[15:8];
            tx_buf[3] <= led_val[7:0];
         end else begin
            tx_buf[0] <= JSTK2_CMD_NOP;
            tx_buf[1] <= JSTK2_CMD_NOP;
            tx_buf[2] <= JSTK2_CMD_NOP;
            tx_buf[3] <= JSTK2_CMD_NOP;
         end
         tx_buf[4] <= JSTK2_CMD_NOP;
      end
      if (byte_done && byte_idx != LAST_BYTE) rx_buf[byte_idx[1:0]] <= rx_byte;
   end

endmodule

// File: tb/tb_jstk2_spi_reader.sv
// Self-checking bench for jstk2_spi_reader: a JSTK2 slave model on MISO/MOSI and a scoreboard
// of expected decodes and expected MOSI packets, with a SWAP_XY=1 twin sharing the inputs.
`timescale 1ns/1ns
module tb_jstk2_spi_reader;

   localparam int HALF = 2, SETUP = 4, BGAP = 3, PGAP = 5;
   localparam int LATENCY = SETUP + 80*HALF + 4*BGAP;   // 176

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       stick;
      logic       trig;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, en, led_wr, miso;
   logic [23:0] led_rgb;
   logic        mosi0, ss0, sclk0, stick0, trig0, dv0, busy0;
   logic        mosi1, ss1, sclk1, stick1, trig1, dv1, busy1;
   logic [9:0]  x0, y0, x1, y1;

   int          total = 0;
   int          bad   = 0;
   int          dv_cnt = 0;
   int          ss_fall_cnt = 0;
   exp_t        exp_q[$];
   logic [39:0] tx_q[$];
   logic [39:0] resp = '0;
   logic [39:0] pkt;
   logic [39:0] mosi_sh;
   int          mosi_cnt = 0;
   int          bit_i = 0;
   time         t_ss = 0;

   always #5 clk = ~clk;

   jstk2_spi_reader #(.SCLK_HALF_CYC(HALF), .SS_SETUP_CYC(SETUP), .BYTE_GAP_CYC(BGAP),
                      .PKT_GAP_CYC(PGAP), .SWAP_XY(0)) dut0 (
      .clk(clk), .rst(rst), .en(en), .led_rgb(led_rgb), .led_wr(led_wr), .MISO(miso),
      .MOSI(mosi0), .SS(ss0), .SCLK(sclk0), .x_val(x0), .y_val(y0),
      .btn_stick(stick0), .btn_trig(trig0), .data_valid(dv0), .busy(busy0));

   jstk2_spi_reader #(.SCLK_HALF_CYC(HALF), .SS_SETUP_CYC(SETUP), .BYTE_GAP_CYC(BGAP),
                      .PKT_GAP_CYC(PGAP), .SWAP_XY(1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .led_rgb(led_rgb), .led_wr(led_wr), .MISO(miso),
      .MOSI(mosi1), .SS(ss1), .SCLK(sclk1), .x_val(x1), .y_val(y1),
      .btn_stick(stick1), .btn_trig(trig1), .data_valid(dv1), .busy(busy1));

   // Reference decode of a {b0,b1,b2,b3,b4} response.
   function automatic exp_t decode_model(input logic [39:0] r);
      exp_t e;
      logic [7:0] b0, b1, b2, b3, b4;
      {b0, b1, b2, b3, b4} = r;
      e.x     = {b1[1:0], b0};
      e.y     = {b3[1:0], b2};
      e.stick = b4[0];
      e.trig  = b4[1];
      return e;
   endfunction

   // JSTK2 model: first bit presented at SS fall, later bits after each SCLK fall.
   always @(negedge ss0) begin
      t_ss     = $time;
      pkt      = resp;
      bit_i    = 0;
      miso     = pkt[39];
      mosi_cnt = 0;
      ss_fall_cnt++;
   end

   always @(negedge sclk0) begin
      if (ss0 === 1'b0 && bit_i < 39) begin
         bit_i++;
         miso = pkt[39-bit_i];
      end
   end

   always @(posedge sclk0) begin
      if (ss0 === 1'b0) begin
         mosi_sh = {mosi_sh[38:0], mosi0};
         mosi_cnt++;
      end
   end

   always @(posedge ss0) begin
      if (rst !== 1'b1) begin
         total++;
         if (tx_q.size() == 0) begin
            bad++;
            $display("FAIL mosi_unexpected: packet of %0d bits, none expected", mosi_cnt);
         end else begin
            logic [39:0] e;
            e = tx_q.pop_front();
            if (mosi_cnt != 40 || mosi_sh !== e) begin
               bad++;
               $display("FAIL mosi_packet: got %0d bits %h, expected 40 bits %h", mosi_cnt, mosi_sh, e);
            end
         end
      end
   end

   // Decode scoreboard, sampled on the falling clock edge.
   always @(negedge clk) begin
      if (dv0 === 1'b1 || dv1 === 1'b1) begin
         total++;
         if (dv0 !== dv1) begin
            bad++;
            $display("FAIL dv_pair: dut0=%b dut1=%b", dv0, dv1);
         end
      end
      if (dv0 === 1'b1) begin
         time lat;
         dv_cnt++;
         lat = ($time - t_ss - 5) / 10;
         total++;
         if (lat != LATENCY) begin
            bad++;
            $display("FAIL latency: got %0d cycles, expected %0d", lat, LATENCY);
         end
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL dv_unexpected: x=%0d y=%0d", x0, y0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (x0 !== e.x || y0 !== e.y || stick0 !== e.stick || trig0 !== e.trig) begin
               bad++;
               $display("FAIL decode: got x=%0d y=%0d s=%b t=%b, expected x=%0d y=%0d s=%b t=%b",
                        x0, y0, stick0, trig0, e.x, e.y, e.stick, e.trig);
            end
            total++;
            if (x1 !== e.y || y1 !== e.x || stick1 !== e.stick || trig1 !== e.trig) begin
               bad++;
               $display("FAIL decode_swap: got x=%0d y=%0d s=%b t=%b, expected x=%0d y=%0d s=%b t=%b",
                        x1, y1, stick1, trig1, e.y, e.x, e.stick, e.trig);
            end
         end
      end
   end

   task automatic wait_ss(input int target, input string name);
      int n = 0;
      while (ss_fall_cnt < target && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (ss_fall_cnt < target) begin
         total++;
         bad++;
         $display("FAIL %s_ss_timeout: got %0d SS falls, expected %0d", name, ss_fall_cnt, target);
      end
   endtask

   task automatic wait_dv(input int target, input string name);
      int n = 0;
      while (dv_cnt < target && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (dv_cnt < target) begin
         total++;
         bad++;
         $display("FAIL %s_dv_timeout: got %0d strobes, expected %0d", name, dv_cnt, target);
      end
   endtask

   task automatic pulse_led(input logic [23:0] rgb);
      led_rgb = rgb;
      led_wr  = 1'b1;
      @(negedge clk);
      led_wr  = 1'b0;
   endtask

   // One packet: enable until SS falls, then let the packet and PGAP finish.
   task automatic run_packet(input logic [39:0] r, input logic [39:0] tx_exp, input string name);
      int ss_t, dv_t;
      ss_t = ss_fall_cnt + 1;
      dv_t = dv_cnt + 1;
      resp = r;
      exp_q.push_back(decode_model(r));
      tx_q.push_back(tx_exp);
      en = 1'b1;
      wait_ss(ss_t, name);
      en = 1'b0;
      total++;
      if (busy0 !== 1'b1) begin
         bad++;
         $display("FAIL %s_busy: got %b, expected 1", name, busy0);
      end
      wait_dv(dv_t, name);
      repeat (PGAP + 4) @(negedge clk);
      total++;
      if (busy0 !== 1'b0 || ss0 !== 1'b1) begin
         bad++;
         $display("FAIL %s_idle: got busy=%b SS=%b, expected busy=0 SS=1", name, busy0, ss0);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      total++;
      if (ss0 !== 1'b1 || sclk0 !== 1'b0 || mosi0 !== 1'b0 || dv0 !== 1'b0 || busy0 !== 1'b0) begin
         bad++;
         $display("FAIL %s_ctrl: got SS=%b SCLK=%b MOSI=%b dv=%b busy=%b, expected 1 0 0 0 0",
                  name, ss0, sclk0, mosi0, dv0, busy0);
      end
      total++;
      if (x0 !== 10'd0 || y0 !== 10'd0 || stick0 !== 1'b0 || trig0 !== 1'b0 ||
          x1 !== 10'd0 || y1 !== 10'd0) begin
         bad++;
         $display("FAIL %s_data: got x=%0d y=%0d s=%b t=%b x1=%0d y1=%0d, expected all 0",
                  name, x0, y0, stick0, trig0, x1, y1);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; led_wr = 1'b0; led_rgb = '0; miso = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");
   endtask

   task automatic test_basic();
      run_packet(40'hF4_01_2C_02_02, 40'h0, "basic");
   endtask

   task automatic test_masking();
      run_packet(40'hFF_FF_00_FC_01, 40'h0, "mask_hi");
      run_packet(40'h00_FC_FF_FF_00, 40'h0, "mask_lo");
   endtask

   task automatic test_led_idle();
      pulse_led(24'h10_20_30);
      run_packet(40'h00_02_FF_03_03, 40'h84_10_20_30_00, "led_idle");
      run_packet(40'h55_01_AA_02_00, 40'h0, "led_cleared");
   endtask

   task automatic test_led_mid_packet();
      int ss_t, dv_t;
      ss_t = ss_fall_cnt + 1;
      dv_t = dv_cnt + 1;
      resp = 40'h01_00_02_00_01;
      exp_q.push_back(decode_model(resp));
      tx_q.push_back(40'h0);
      en = 1'b1;
      wait_ss(ss_t, "led_mid");
      en = 1'b0;
      repeat (20) @(negedge clk);
      pulse_led(24'hFF_00_00);
      repeat (30) @(negedge clk);
      pulse_led(24'h00_FF_00);
      wait_dv(dv_t, "led_mid");
      repeat (PGAP + 4) @(negedge clk);
      run_packet(40'h10_03_20_01_02, 40'h84_00_FF_00_00, "led_mid_next");
   endtask

   task automatic test_back_to_back();
      int ss_t, dv_t;
      ss_t = ss_fall_cnt + 1;
      dv_t = dv_cnt + 2;
      resp = 40'h33_02_44_01_01;
      exp_q.push_back(decode_model(resp));
      tx_q.push_back(40'h0);
      en = 1'b1;
      wait_ss(ss_t, "b2b_first");
      repeat (10) @(negedge clk);
      resp = 40'hCC_01_DD_02_02;
      exp_q.push_back(decode_model(resp));
      tx_q.push_back(40'h0);
      wait_ss(ss_t + 1, "b2b_second");
      en = 1'b0;
      wait_dv(dv_t, "b2b");
      repeat (PGAP + 4) @(negedge clk);
   endtask

   task automatic test_en_drop();
      int ss_t, dv_t, ss_seen;
      logic ss_low;
      ss_t = ss_fall_cnt + 1;
      dv_t = dv_cnt + 1;
      resp = 40'h7F_03_80_00_03;
      exp_q.push_back(decode_model(resp));
      tx_q.push_back(40'h0);
      en = 1'b1;
      wait_ss(ss_t, "en_drop");
      repeat (20) @(negedge clk);
      en = 1'b0;
      wait_dv(dv_t, "en_drop");
      ss_seen = ss_fall_cnt;
      ss_low  = 1'b0;
      repeat (300) begin
         @(negedge clk);
         if (ss0 !== 1'b1) ss_low = 1'b1;
      end
      total++;
      if (ss_low || dv_cnt != dv_t || ss_fall_cnt != ss_seen) begin
         bad++;
         $display("FAIL en_drop_idle: got ss_low=%b strobes=%0d falls=%0d, expected 0 %0d %0d",
                  ss_low, dv_cnt, ss_fall_cnt, dv_t, ss_seen);
      end
   endtask

   task automatic test_reset_mid();
      int ss_t, dv_seen;
      ss_t = ss_fall_cnt + 1;
      resp = 40'hAB_02_CD_01_03;
      en = 1'b1;
      wait_ss(ss_t, "rst_mid");
      repeat (30) @(negedge clk);
      dv_seen = dv_cnt;
      rst = 1'b1;
      en  = 1'b0;
      @(negedge clk);
      check_reset_outputs("rst_mid");
      rst = 1'b0;
      repeat (300) @(negedge clk);
      total++;
      if (dv_cnt != dv_seen || ss_fall_cnt != ss_t || ss0 !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid_quiet: got strobes=%0d falls=%0d SS=%b, expected %0d %0d 1",
                  dv_cnt, ss_fall_cnt, ss0, dv_seen, ss_t);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_masking();
      test_led_idle();
      test_led_mid_packet();
      test_back_to_back();
      test_en_drop();
      test_reset_mid();
      total++;
      if (exp_q.size() != 0 || tx_q.size() != 0) begin
         bad++;
         $display("FAIL leftover: got %0d decodes %0d packets pending, expected 0 0",
                  exp_q.size(), tx_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
